// File: rtl/rx_deser.sv
// rx_deser: serial-to-parallel receiver for the tx bit-stream interface.
//
// Accepts one bit per tx_valid/rx_ready handshake and assembles WIDTH-bit words.
// Each word goes out on a valid/ready port. A frame starts when i_rx_en rises
// and ends on i_tx_finish. A trailing partial word is flushed zero-padded and
// flagged with o_frame_err.
//
// Ports:
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   i_rx_en       frame enable: 0->1 starts a frame, 1->0 aborts or releases it
//   i_tx_data     serial data bit
//   i_tx_valid    i_tx_data is valid this cycle
//   i_tx_finish   transmitter ended the frame
//   o_rx_ready    receiver accepts a bit this cycle (registered state only)
//   o_word_data   assembled word
//   o_word_valid  o_word_data holds an undelivered word
//   i_word_ready  downstream consumes the word
//   o_frame_done  frame complete (high in DONE)
//   o_frame_err   frame ended on a partial word; sticky until the next frame
//   o_word_count  words loaded into the output register this frame (saturating)
module rx_deser #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MSB_FIRST = 1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_rx_en,
  input  logic             i_tx_data,
  input  logic             i_tx_valid,
  input  logic             i_tx_finish,
  output logic             o_rx_ready,
  output logic [WIDTH-1:0] o_word_data,
  output logic             o_word_valid,
  input  logic             i_word_ready,
  output logic             o_frame_done,
  output logic             o_frame_err,
  output logic [CNT_W-1:0] o_word_count
);

  localparam int unsigned BCW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StRecv, StFlush, StDone} state_e;

  state_e           r_state, w_state_next;
  logic [BCW-1:0]   r_bit_cnt;
  logic [WIDTH-1:0] r_sr;
  logic             r_sr_full;
  logic [WIDTH-1:0] r_word_data;
  logic             r_word_valid;
  logic             r_frame_err;
  logic [CNT_W-1:0] r_word_count;

  logic             w_out_free;
  logic             w_start;
  logic             w_abort;
  logic             w_take;
  logic             w_last;
  logic [BCW-1:0]   w_bit_pos;
  logic [WIDTH-1:0] w_sr_ins;
  logic             w_load;
  logic             w_load_partial;
  logic [WIDTH-1:0] w_load_data;

  assign w_out_free = !r_word_valid || i_word_ready;
  assign w_start    = (r_state == StIdle) && i_rx_en;
  assign w_abort    = (r_state == StRecv) && !i_rx_en;
  assign w_take     = (r_state == StRecv) && i_rx_en && !r_sr_full && i_tx_valid;
  assign w_last     = w_take && (r_bit_cnt == BCW'(WIDTH - 1));

  // Bits are written straight into their final position; the register is
  // cleared whenever a word leaves, so a flushed partial word is zero-padded.
  assign w_bit_pos = (MSB_FIRST != 0) ? (BCW'(WIDTH - 1) - r_bit_cnt) : r_bit_cnt;

  always_comb begin
    w_sr_ins            = r_sr;
    w_sr_ins[w_bit_pos] = i_tx_data;
  end

  // Output-register load: a parked full word first, then a just-completed
  // word, then the zero-padded tail during flush.
  always_comb begin
    w_load         = 1'b0;
    w_load_partial = 1'b0;
    w_load_data    = r_sr;
    if (r_sr_full && w_out_free &&
        ((r_state == StFlush) || ((r_state == StRecv) && i_rx_en))) begin
      w_load = 1'b1;
    end else if (w_last && w_out_free) begin
      w_load      = 1'b1;
      w_load_data = w_sr_ins;
    end else if ((r_state == StFlush) && !r_sr_full && (r_bit_cnt != '0) && w_out_free) begin
      w_load         = 1'b1;
      w_load_partial = 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= StIdle;
    else        r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (i_rx_en) w_state_next = StRecv;
      StRecv: begin
        if (!i_rx_en)         w_state_next = StIdle;
        else if (i_tx_finish) w_state_next = StFlush;
      end
      StFlush: if (!r_sr_full && ((r_bit_cnt == '0) || w_out_free)) w_state_next = StDone;
      StDone:  if (!i_rx_en) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Outputs decoded from registered state
  always_comb begin
    o_rx_ready   = (r_state == StRecv) && !r_sr_full;
    o_frame_done = (r_state == StDone);
  end

  // Shift register and bit counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt <= '0;
      r_sr      <= '0;
      r_sr_full <= 1'b0;
    end else if (w_start || w_abort) begin
      r_bit_cnt <= '0;
      r_sr      <= '0;
      r_sr_full <= 1'b0;
    end else begin
      if (w_load) begin
        r_sr      <= '0;
        r_sr_full <= 1'b0;
      end
      if (w_load_partial) r_bit_cnt <= '0;
      if (w_take) begin
        if (w_last) begin
          r_bit_cnt <= '0;
          // Output busy: park the word and stall the serial side.
          if (!w_out_free) begin
            r_sr      <= w_sr_ins;
            r_sr_full <= 1'b1;
          end
        end else begin
          r_sr      <= w_sr_ins;
          r_bit_cnt <= r_bit_cnt + BCW'(1);
        end
      end
    end
  end

  // Output word register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word_data  <= '0;
      r_word_valid <= 1'b0;
    end else if (w_load) begin
      r_word_data  <= w_load_data;
      r_word_valid <= 1'b1;
    end else if (r_word_valid && i_word_ready) begin
      r_word_valid <= 1'b0;
    end
  end

  // Frame status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word_count <= '0;
      r_frame_err  <= 1'b0;
    end else if (w_start) begin
      r_word_count <= '0;
      r_frame_err  <= 1'b0;
    end else begin
      if (w_load && (r_word_count != '1)) r_word_count <= r_word_count + CNT_W'(1);
      if (w_load_partial)                 r_frame_err  <= 1'b1;
    end
  end

  assign o_word_data  = r_word_data;
  assign o_word_valid = r_word_valid;
  assign o_frame_err  = r_frame_err;
  assign o_word_count = r_word_count;

endmodule

// File: doc/rx_deser.md
Name: rx_deser

Overview:
- Serial receiver for the `tx` bit-stream interface (`tx_data`/`tx_valid`/`tx_finish`, with `rx_ready` as backpressure).
- Accepts one bit per handshake and assembles WIDTH-bit words.
- Presents each word on a valid/ready output port.
- Flags end-of-frame on `tx_finish`.
- Sits between `tx` and the downstream consumer (buffer, register file or core load path).

Parameters:
- WIDTH, 8, bits per assembled word (≥2).
- MSB_FIRST, 1, 1 = first received bit lands in word bit WIDTH-1; 0 = first bit lands in bit 0.
- CNT_W, 16, width of `word_count`.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- rx_en  in  1  enable: start (0→1 path) and release/abort (1→0) of a frame.
- tx_data  in  1  serial data bit from the transmitter.
- tx_valid  in  1  `tx_data` is valid this cycle.
- tx_finish  in  1  transmitter has ended the frame.
- rx_ready  out  1  receiver accepts a bit this cycle.
- word_data  out  WIDTH  assembled word.
- word_valid  out  1  `word_data` holds an undelivered word.
- word_ready  in  1  downstream consumes the word when high together with `word_valid`.
- frame_done  out  1  frame complete; held high in DONE.
- frame_err  out  1  frame ended on a partial word; sticky until the next frame.
- word_count  out  CNT_W  words loaded into the output register this frame; saturates at all-ones.

Behaviour:
- Reset (async, `rst_n`=0): state=IDLE; bit_cnt=0; sr_full=0; `rx_ready`=0, `word_data`=0, `word_valid`=0, `frame_done`=0, `frame_err`=0, `word_count`=0.
- Bit accept: a bit is taken on an edge where `tx_valid`=1 and `rx_ready`=1. `tx_data` is ignored otherwise.
- `rx_ready` = (state==RECV) && !sr_full. It is combinational from registered state only, with no combinational path from any input.
- Output-free condition: `word_valid`==0, or (`word_valid` && `word_ready`) on the same edge.
- States and transitions:
  - IDLE: `rx_ready`=0. `rx_en`=1 → RECV next edge. On entry to RECV: bit_cnt, sr_full, `word_count`, `frame_err`, `frame_done` are cleared.
  - RECV, bit taken: bit shifts into the shift register in the order set by MSB_FIRST; bit_cnt increments.
  - RECV, WIDTH-th bit taken:
    - Output free: load `word_data` and set `word_valid` on that edge. The word is visible the cycle after its last bit. `word_count`+1. bit_cnt→0.
    - Output not free: sr_full=1, so `rx_ready`=0 from the next cycle. Transfer happens on the first edge the output is free; sr_full clears on that edge; `rx_ready` returns the following cycle.
  - RECV, `tx_finish`=1: any bit handshaked on the same edge is taken first, then state→FLUSH.
  - RECV, `rx_en`=0: abort → IDLE. Partial bits are discarded. The output register and `word_valid` are untouched.
  - FLUSH, bit_cnt==0 and sr_full==0: → DONE next edge.
  - FLUSH, full word pending (sr_full=1): load it when the output is free (counts as a normal word), then apply the partial/empty checks.
  - FLUSH, partial word (bit_cnt>0): received bits occupy the first positions per bit order; the remaining bits are 0. Load when the output is free, set `frame_err`=1, `word_count`+1, → DONE.
  - DONE: `frame_done`=1, `rx_ready`=0. `word_valid`/`word_ready` keep operating until the last word drains. `rx_en`=0 → IDLE, clearing `frame_done`; `frame_err` and `word_count` hold until the next frame start.
- `word_valid` drop: clears on a handshake edge unless a new word is loaded on that same edge. `word_data` is stable while `word_valid`=1 && `word_ready`=0.
- `tx_finish` outside RECV is ignored.
- `word_count` saturates at 2^CNT_W−1.
- Reset asserted mid-frame returns to reset values immediately (async), with no partial output.

Test Plan:
- WIDTH=8, MSB_FIRST=1, `word_ready`=1, bits 1,0,1,0,0,1,0,1 then `tx_finish` → `word_data`=0xA5, `word_valid` high one cycle after the 8th bit, `word_count`=1, `frame_done`=1, `frame_err`=0.
- Same stream with MSB_FIRST=0 → `word_data`=0xA5 (bits reversed; first bit is bit 0).
- Two words 0x3C, 0xC3 with `word_ready`=0 → first word held stable; after the 16th bit `rx_ready` drops; raising `word_ready` delivers 0x3C then 0xC3 in order; `word_count`=2; no bit lost.
- Bits 1,0,1 then `tx_finish` → `word_data`=0xA0 (MSB_FIRST=1), `frame_err`=1, `word_count`=1, `frame_done`=1.
- `tx_finish` on the same edge as the 8th bit → that word delivered, `frame_err`=0, DONE reached.
- `rst_n` pulsed low after 4 bits → all outputs 0 immediately; a new frame after `rx_en` delivers a correct full word.
